alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder; consumes its 3-bit alu_control code plus register operands and produces the result and zero flag.
- add/sub/and/or/slt complete in one cycle.
- sll/srl use an iterative 1-bit-per-cycle shifter, so the block exposes a start/busy/done handshake to the multicycle datapath controller.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- alu_control  input  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 reserved, 6 sll, 7 srl.
- operand_a  input  WIDTH  rs operand.
- operand_b  input  WIDTH  rt operand; this is the shifted operand for sll/srl.
- shamt  input  SHAMT_W  shift amount.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse when result/zero are updated.
- result  output  WIDTH  registered result; holds its value until the next completion.
- zero  output  1  registered; equals (result == 0), updated together with result.
- overflow  output  1  present only with ALU_OVF_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - busy, done, zero, overflow = 0; result = 0; shift counter = 0.
  - Reset asserted mid-shift aborts the shift; no done pulse is produced.
- States: IDLE and SHIFT. busy = (state == SHIFT).
- Accept: on a rising edge with state = IDLE and start = 1, operands, alu_control and shamt are latched. Inputs are ignored while busy.
- Single-cycle path, codes 0-5, or codes 6/7 with shamt = 0. At the accept edge:
  - add: a+b mod 2^WIDTH.
  - sub: a-b mod 2^WIDTH.
  - and: a&b.
  - or: a|b.
  - slt: 1 if signed a < signed b, else 0, zero-extended.
  - reserved code 5: result 0.
  - Codes 6/7 with shamt = 0: result = b.
  - done = 1 for exactly one cycle; state stays IDLE.
- Shift path, codes 6/7 with shamt = n > 0:
  - Accept edge: work register <= b, counter <= n, state -> SHIFT, done = 0.
  - Each SHIFT edge: work shifts one bit (sll left, zero fill; srl logical right, zero fill) and counter decrements.
  - On the edge where counter = 1: result <= final shifted value, zero updated, done = 1, state -> IDLE.
  - Total latency is n edges from acceptance. busy is high for n cycles.
- done is deasserted on every edge that does not complete an operation.
- Back-to-back: start may be high in the cycle done is high (state IDLE); the new operation is accepted on that edge.
- shamt >= WIDTH, possible only if 2**SHAMT_W > WIDTH: iterates fully and yields 0.
- result, zero and overflow are never modified on edges that do not complete an operation.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined:
  - overflow port exists and is registered with result.
  - add: 1 when a and b have the same sign and the sum's sign differs.
  - sub: 1 when a and b have different signs and the difference's sign differs from a.
  - All other codes: 0.
- Undefined: overflow port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-shift: start sll, b=1, shamt=20; assert rst_n=0 after 5 cycles -> busy=0 and result=0 immediately; no done pulse after release.
- add then sub back-to-back, start held high:
  - a=0x00000005, b=0x00000007, code 0 -> result=0x0000000C, zero=0, done pulses after 1 edge.
  - Next, code 1, a=b=0x12345678 -> result=0, zero=1.
- slt signed: a=0xFFFFFFFF, b=0x00000001, code 4 -> result=1. Swap operands -> result=0.
- sll iterative: b=0x00000003, shamt=4, code 6 -> busy high 4 cycles, done on the 4th edge after accept, result=0x00000030. start pulses during busy are ignored.
- srl boundaries:
  - b=0x80000000, shamt=31, code 7 -> result=0x00000001 after 31 edges.
  - Same with shamt=0 -> result=0x80000000 in 1 edge, busy never asserted.
- ALU_OVF_EN:
  - a=0x7FFFFFFF, b=1, add -> result=0x80000000, overflow=1.
  - a=0x80000000, b=1, sub -> overflow=1.
  - and with any operands -> overflow=0.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops plus an iterative 1-bit-per-cycle shifter.
// Optional macro ALU_OVF_EN adds a registered signed-overflow flag for add/sub.
module alu_seq_exec #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         alu_control,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               zero
`ifdef ALU_OVF_EN
   ,
   output logic               overflow
`endif
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               done_q, done_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   sum, diff, alu_res, shifted;
   logic               slt, alu_ovf, is_shift;

   assign sum      = operand_a + operand_b;
   assign diff     = operand_a - operand_b;
   assign slt      = $signed(operand_a) < $signed(operand_b);
   assign is_shift = (alu_control[2:1] == 2'b11) && (shamt != '0);
   // dir_q = 1 selects logical right shift
   assign shifted  = dir_q ? (work_q >> 1) : (work_q << 1);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_control)
         3'd0: begin
            alu_res = sum;
            alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         3'd1: begin
            alu_res = diff;
            alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != operand_a[WIDTH-1]);
         end
         3'd2:       alu_res = operand_a & operand_b;
         3'd3:       alu_res = operand_a | operand_b;
         3'd4:       alu_res = {{(WIDTH-1){1'b0}}, slt};
         3'd6, 3'd7: alu_res = operand_b;
         default:    alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (is_shift) begin
                  work_d  = operand_b;
                  cnt_d   = shamt;
                  dir_d   = alu_control[0];
                  state_d = StShift;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  done_d   = 1'b1;
               end
            end
         end
         StShift: begin
            work_d = shifted;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = shifted;
               zero_d   = (shifted == '0);
               ovf_d    = 1'b0;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         work_q   <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q == StShift);
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
`ifdef ALU_OVF_EN
   assign overflow = ovf_q;
`else
   // Flag is computed but has no consumer without the overflow port
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec; hand-computed expected values.
module tb_alu_seq_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  alu_control;
   logic [31:0] operand_a, operand_b;
   logic [4:0]  shamt;
   logic        busy, done, zero;
   logic [31:0] result;
`ifdef ALU_OVF_EN
   logic        overflow;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu_control (alu_control),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .shamt       (shamt),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .zero        (zero)
`ifdef ALU_OVF_EN
      ,
      .overflow    (overflow)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      alu_control = code;
      operand_a   = a;
      operand_b   = b;
      shamt       = sh;
      start       = 1'b1;
   endtask

   initial begin
      int  n;
      logic seen_done;
      rst_n = 1'b0;
      start = 1'b0;
      alu_control = 3'd0;
      operand_a = '0;
      operand_b = '0;
      shamt = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      step();
      rst_n = 1'b1;

      // add then sub back-to-back with start held
      drive(3'd0, 32'h5, 32'h7, 5'd0);
      step();
      chk("add_done", done, 1);
      chk("add_result", result, 32'h0000000C);
      chk("add_zero", zero, 0);
      chk("add_busy", busy, 0);
      drive(3'd1, 32'h12345678, 32'h12345678, 5'd0);
      step();
      chk("sub_done", done, 1);
      chk("sub_result", result, 0);
      chk("sub_zero", zero, 1);
      start = 1'b0;
      step();
      chk("idle_done", done, 0);
      chk("idle_hold", result, 0);

      drive(3'd4, 32'hFFFFFFFF, 32'h1, 5'd0);
      step();
      chk("slt_neg", result, 1);
      chk("slt_neg_zero", zero, 0);
      drive(3'd4, 32'h1, 32'hFFFFFFFF, 5'd0);
      step();
      chk("slt_pos", result, 0);
      drive(3'd1, 32'd10, 32'd3, 5'd0);
      step();
      chk("sub_10_3", result, 7);
      drive(3'd0, 32'hFFFFFFFF, 32'h1, 5'd0);
      step();
      chk("add_wrap", result, 0);
      chk("add_wrap_zero", zero, 1);
      drive(3'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0);
      step();
      chk("and", result, 32'h0000F000);
      drive(3'd5, 32'h1, 32'h2, 5'd0);
      step();
      chk("reserved", result, 0);
      chk("reserved_done", done, 1);
      drive(3'd3, 32'h0000F0F0, 32'h00000F0F, 5'd0);
      step();
      chk("or", result, 32'h0000FFFF);

      // sll by 4 with start kept high during busy
      drive(3'd6, 32'h0, 32'h3, 5'd4);
      step();
      chk("sll_busy0", busy, 1);
      chk("sll_done0", done, 0);
      chk("sll_hold", result, 32'h0000FFFF);
      drive(3'd0, 32'h1, 32'h1, 5'd0);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("sll_busy", busy, 1);
         chk("sll_nodone", done, 0);
      end
      step();
      chk("sll_done", done, 1);
      chk("sll_idle", busy, 0);
      chk("sll_result", result, 32'h00000030);
      start = 1'b0;
      step();
      chk("sll_after", done, 0);
      chk("sll_after_res", result, 32'h00000030);

      // srl by 31: latency measured in edges
      drive(3'd7, 32'h0, 32'h80000000, 5'd31);
      step();
      start = 1'b0;
      chk("srl31_busy", busy, 1);
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      chk("srl31_latency", n, 31);
      chk("srl31_result", result, 1);
      chk("srl31_idle", busy, 0);

      drive(3'd7, 32'h0, 32'h80000000, 5'd0);
      step();
      start = 1'b0;
      chk("srl0_done", done, 1);
      chk("srl0_busy", busy, 0);
      chk("srl0_result", result, 32'h80000000);

      // reset mid-shift aborts without done
      drive(3'd6, 32'h0, 32'h1, 5'd20);
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_done", done, 0);
      #2;
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         seen_done = seen_done | done;
      end
      chk("mid_no_done", seen_done, 0);

`ifdef ALU_OVF_EN
      drive(3'd0, 32'h7FFFFFFF, 32'h1, 5'd0);
      step();
      chk("ovf_add_res", result, 32'h80000000);
      chk("ovf_add", overflow, 1);
      drive(3'd1, 32'h80000000, 32'h1, 5'd0);
      step();
      chk("ovf_sub_res", result, 32'h7FFFFFFF);
      chk("ovf_sub", overflow, 1);
      drive(3'd2, 32'hFFFFFFFF, 32'h80000000, 5'd0);
      step();
      chk("ovf_and", overflow, 0);
      drive(3'd0, 32'h5, 32'h7, 5'd0);
      step();
      chk("ovf_add_none", overflow, 0);
      start = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
